// File: rtl/cheb_stim_source.sv
// AXI-Stream stimulus generator (impulse / step / ramp / square) with full backpressure support.
// Optional m_axis_last output enabled by defining CHEB_SRC_LAST_EN.
module cheb_stim_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] amplitude,
    input  logic [DATA_WIDTH-1:0] ramp_step,
    input  logic [LEN_WIDTH-1:0]  half_period,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    input  logic                  m_axis_ready,
`ifdef CHEB_SRC_LAST_EN
    output logic                  m_axis_last,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  sample_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state;

    logic [1:0]            mode_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] amp_q;
    logic [DATA_WIDTH-1:0] step_q;
    logic [LEN_WIDTH-1:0]  hp_q;
    logic [LEN_WIDTH-1:0]  n;
    logic [DATA_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0]  sq_cnt;
    logic                  sq_neg;
    logic                  abort_q;
    logic                  last_q;

    logic [LEN_WIDTH:0]    n_next_w;
    logic                  more;
    logic                  next_is_last;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [LEN_WIDTH-1:0]  sq_cnt_next;
    logic                  sq_neg_next;
    logic [DATA_WIDTH-1:0] sample_next;

    assign busy = (state != S_IDLE);

    // Next-sample precomputation so the following beat can be registered on the handshake edge.
    always_comb begin
        n_next_w     = {1'b0, n} + (LEN_WIDTH+1)'(1);
        more         = n_next_w < {1'b0, len_q};
        next_is_last = (n_next_w + (LEN_WIDTH+1)'(1)) == {1'b0, len_q};
        acc_next     = acc + step_q;
        sq_cnt_next  = sq_cnt + LEN_WIDTH'(1);
        sq_neg_next  = sq_neg;
        if (({1'b0, sq_cnt} + (LEN_WIDTH+1)'(1)) == {1'b0, hp_q}) begin
            sq_cnt_next = '0;
            sq_neg_next = ~sq_neg;
        end
        case (mode_q)
            2'd0:    sample_next = '0;
            2'd1:    sample_next = amp_q;
            2'd2:    sample_next = acc_next;
            default: sample_next = sq_neg_next ? ('0 - amp_q) : amp_q;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state        <= S_IDLE;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            done         <= 1'b0;
            sample_count <= '0;
            mode_q       <= '0;
            len_q        <= '0;
            amp_q        <= '0;
            step_q       <= '0;
            hp_q         <= '0;
            n            <= '0;
            acc          <= '0;
            sq_cnt       <= '0;
            sq_neg       <= 1'b0;
            abort_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q       <= mode;
                        len_q        <= frame_len;
                        amp_q        <= amplitude;
                        step_q       <= ramp_step;
                        hp_q         <= (half_period == '0) ? LEN_WIDTH'(1) : half_period;
                        n            <= '0;
                        acc          <= '0;
                        sq_cnt       <= '0;
                        sq_neg       <= 1'b0;
                        abort_q      <= 1'b0;
                        sample_count <= '0;
                        if (frame_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= S_RUN;
                            m_axis_valid <= 1'b1;
                            m_axis_data  <= (mode == 2'd2) ? '0 : amplitude;
                            last_q       <= (frame_len == LEN_WIDTH'(1));
                        end
                    end
                end
                S_RUN: begin
                    if (abort) abort_q <= 1'b1;
                    if (m_axis_ready) begin
                        sample_count <= sample_count + LEN_WIDTH'(1);
                        if (more && !abort_q && !abort) begin
                            n           <= n_next_w[LEN_WIDTH-1:0];
                            acc         <= acc_next;
                            sq_cnt      <= sq_cnt_next;
                            sq_neg      <= sq_neg_next;
                            m_axis_data <= sample_next;
                            last_q      <= next_is_last;
                        end else begin
                            m_axis_valid <= 1'b0;
                            last_q       <= 1'b0;
                            state        <= S_DONE;
                            done         <= 1'b1;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CHEB_SRC_LAST_EN
    assign m_axis_last = last_q;
`endif

endmodule

// File: tb/tb_cheb_stim_source.sv
// Directed self-checking bench for cheb_stim_source; checks m_axis_last when CHEB_SRC_LAST_EN is defined.
module tb_cheb_stim_source;

    logic        clk = 1'b0;
    logic        axi_reset;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] frame_len;
    logic [31:0] amplitude;
    logic [31:0] ramp_step;
    logic [15:0] half_period;
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sample_count;
`ifdef CHEB_SRC_LAST_EN
    logic        last;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cheb_stim_source #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .axi_clk      (clk),
        .axi_reset    (axi_reset),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .frame_len    (frame_len),
        .amplitude    (amplitude),
        .ramp_step    (ramp_step),
        .half_period  (half_period),
        .m_axis_valid (valid),
        .m_axis_data  (data),
        .m_axis_ready (ready),
`ifdef CHEB_SRC_LAST_EN
        .m_axis_last  (last),
`endif
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [15:0] len, input logic [31:0] amp,
                            input logic [31:0] stp, input logic [15:0] hp);
        mode = m; frame_len = len; amplitude = amp; ramp_step = stp; half_period = hp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        axi_reset = 1'b1;
        tick(); tick();
        tests++;
        if ({valid, data, busy, done, sample_count} !== 50'd0) begin
            fails++;
            $display("FAIL reset: valid=%b data=%h busy=%b done=%b cnt=%0d, want all 0",
                     valid, data, busy, done, sample_count);
        end
`ifdef CHEB_SRC_LAST_EN
        tests++;
        if (last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", last); end
`endif
        axi_reset = 1'b0;
        tick();
    endtask

    task automatic test_impulse();
        logic [31:0] exp_d [4] = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        ready = 1'b1;
        do_start(2'd0, 16'd4, 32'h4000_0000, 32'd0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (valid !== 1'b1 || data !== exp_d[i]) begin
                fails++;
                $display("FAIL impulse_beat%0d: valid=%b data=%h want 1 %h", i, valid, data, exp_d[i]);
            end
`ifdef CHEB_SRC_LAST_EN
            tests++;
            if (last !== (i == 3)) begin fails++; $display("FAIL impulse_last%0d: got %b", i, last); end
`endif
            tick();
        end
        tests++;
        if (valid !== 1'b0 || done !== 1'b1 || sample_count !== 16'd4 || busy !== 1'b1) begin
            fails++;
            $display("FAIL impulse_end: valid=%b done=%b cnt=%0d busy=%b want 0 1 4 1",
                     valid, done, sample_count, busy);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || sample_count !== 16'd4) begin
            fails++;
            $display("FAIL impulse_idle: done=%b busy=%b cnt=%0d want 0 0 4", done, busy, sample_count);
        end
    endtask

    task automatic test_ramp_backpressure();
        logic [31:0] exp_d [3] = '{32'h0, 32'h8000_0000, 32'h0};
        int k = 0;
        logic        pv;
        logic        pr;
        logic [31:0] pd;
        ready = 1'b0;
        do_start(2'd2, 16'd3, 32'd0, 32'h8000_0000, 16'd0);
        for (int c = 0; c < 20 && k < 3; c++) begin
            ready = c[0];
            pv = valid; pr = ready; pd = data;
            if (valid && ready) begin
                tests++;
                if (data !== exp_d[k]) begin
                    fails++;
                    $display("FAIL ramp_beat%0d: data=%h want %h", k, data, exp_d[k]);
                end
                k++;
            end
            tick();
            if (pv && !pr) begin
                tests++;
                if (valid !== 1'b1 || data !== pd) begin
                    fails++;
                    $display("FAIL ramp_stall: valid=%b data=%h want 1 %h", valid, data, pd);
                end
            end
        end
        tests++;
        if (k != 3 || valid !== 1'b0 || done !== 1'b1 || sample_count !== 16'd3) begin
            fails++;
            $display("FAIL ramp_end: beats=%0d valid=%b done=%b cnt=%0d want 3 0 1 3",
                     k, valid, done, sample_count);
        end
        ready = 1'b1;
        tick();
    endtask

    task automatic test_square();
        logic [31:0] exp_a [6] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd5, 32'd5};
        logic [31:0] exp_b [6] = '{32'd5, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFB};
        ready = 1'b1;
        do_start(2'd3, 16'd6, 32'd5, 32'd0, 16'd2);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (valid !== 1'b1 || data !== exp_a[i]) begin
                fails++;
                $display("FAIL square_hp2_%0d: valid=%b data=%h want 1 %h", i, valid, data, exp_a[i]);
            end
            tick();
        end
        tick();
        do_start(2'd3, 16'd6, 32'd5, 32'd0, 16'd0);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (valid !== 1'b1 || data !== exp_b[i]) begin
                fails++;
                $display("FAIL square_hp0_%0d: valid=%b data=%h want 1 %h", i, valid, data, exp_b[i]);
            end
            tick();
        end
        tick();
        // most-negative amplitude negates to itself
        do_start(2'd3, 16'd2, 32'h8000_0000, 32'd0, 16'd1);
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (valid !== 1'b1 || data !== 32'h8000_0000) begin
                fails++;
                $display("FAIL square_minneg_%0d: valid=%b data=%h want 1 80000000", i, valid, data);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_abort();
        ready = 1'b1;
        do_start(2'd1, 16'd100, 32'd7, 32'd0, 16'd0);
        tick(); tick();
        ready = 1'b0;
        amplitude = 32'd99; mode = 2'd2; frame_len = 16'd1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        tests++;
        if (valid !== 1'b1 || data !== 32'd7 || sample_count !== 16'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_hold: valid=%b data=%h cnt=%0d busy=%b want 1 7 2 1",
                     valid, data, sample_count, busy);
        end
`ifdef CHEB_SRC_LAST_EN
        tests++;
        if (last !== 1'b0) begin fails++; $display("FAIL abort_last: got %b want 0", last); end
`endif
        ready = 1'b1;
        tick();
        tests++;
        if (valid !== 1'b0 || done !== 1'b1 || sample_count !== 16'd3) begin
            fails++;
            $display("FAIL abort_end: valid=%b done=%b cnt=%0d want 0 1 3", valid, done, sample_count);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || valid !== 1'b0 || sample_count !== 16'd3) begin
            fails++;
            $display("FAIL abort_idle: busy=%b valid=%b cnt=%0d want 0 0 3", busy, valid, sample_count);
        end
    endtask

    task automatic test_len_zero();
        ready = 1'b1;
        do_start(2'd1, 16'd0, 32'd1, 32'd0, 16'd0);
        tests++;
        if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL len0_done: valid=%b done=%b busy=%b want 0 1 1", valid, done, busy);
        end
        tick();
        tests++;
        if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || sample_count !== 16'd0) begin
            fails++;
            $display("FAIL len0_idle: valid=%b done=%b busy=%b cnt=%0d want 0 0 0 0",
                     valid, done, busy, sample_count);
        end
    endtask

    task automatic test_start_with_abort();
        ready = 1'b1;
        abort = 1'b1;
        do_start(2'd1, 16'd2, 32'd3, 32'd0, 16'd0);
        abort = 1'b0;
        tick(); tick();
        tests++;
        if (done !== 1'b1 || sample_count !== 16'd2) begin
            fails++;
            $display("FAIL start_abort: done=%b cnt=%0d want 1 2", done, sample_count);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        ready = 1'b1;
        do_start(2'd2, 16'd10, 32'd0, 32'd1, 16'd0);
        tick(); tick();
        ready = 1'b0;
        tests++;
        if (valid !== 1'b1 || data !== 32'd2) begin
            fails++;
            $display("FAIL rst_mid_beat2: valid=%b data=%h want 1 2", valid, data);
        end
        axi_reset = 1'b1;
        tick();
        tests++;
        if (valid !== 1'b0 || data !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || sample_count !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid: valid=%b data=%h busy=%b done=%b cnt=%0d want 0 0 0 0 0",
                     valid, data, busy, done, sample_count);
        end
        axi_reset = 1'b0;
        ready = 1'b1;
        tick();
        do_start(2'd2, 16'd2, 32'd0, 32'd3, 16'd0);
        tests++;
        if (valid !== 1'b1 || data !== 32'd0) begin
            fails++;
            $display("FAIL rst_restart0: valid=%b data=%h want 1 0", valid, data);
        end
        tick();
        tests++;
        if (valid !== 1'b1 || data !== 32'd3) begin
            fails++;
            $display("FAIL rst_restart1: valid=%b data=%h want 1 3", valid, data);
        end
        tick(); tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        mode = 2'd0; frame_len = '0; amplitude = '0; ramp_step = '0; half_period = '0;
        test_reset();
        test_impulse();
        test_ramp_backpressure();
        test_square();
        test_abort();
        test_len_zero();
        test_start_with_abort();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
